// File: rtl/frame_sync_ctrl.sv
// Frame scheduler between the game statemachine and the PPU: ticks the statemachine on
// each vsync falling edge and double-buffers its attributes so they change only at frame boundaries.
module frame_sync_ctrl #(
  parameter int SPRITE_W = 64,
  parameter int STATIC_W = 1,
  parameter int TIMEOUT  = 1800000,
  parameter int FCNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync,
  input  logic                enable,
  input  logic                clear_flags,
  output logic                sm_tick,
  input  logic                sm_done,
  input  logic [SPRITE_W-1:0] sm_sprites,
  input  logic [STATIC_W-1:0] sm_statics,
  output logic [SPRITE_W-1:0] ppu_sprites,
  output logic [STATIC_W-1:0] ppu_statics,
  output logic [FCNT_W-1:0]   frame_count,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TICK, WAIT} state_t;

  state_t              state, state_nxt;
  logic                vsync_q;
  logic                vs_fall;
  logic [SPRITE_W-1:0] stage_sprites;
  logic [STATIC_W-1:0] stage_statics;
  logic                pending;
  logic [TMR_W-1:0]    timer;

  logic stage_load;
  logic commit_stage;
  logic commit_direct;
  logic set_overrun;
  logic set_timeout;

  // vsync_q resets low, so a vsync held high through reset never looks like an edge.
  assign vs_fall = vsync_q & ~vsync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt     = state;
    stage_load    = 1'b0;
    commit_stage  = 1'b0;
    commit_direct = 1'b0;
    set_overrun   = 1'b0;
    set_timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (vs_fall && enable) begin
          commit_stage = pending;
          state_nxt    = TICK;
        end
      end
      TICK: state_nxt = WAIT;
      WAIT: begin
        if (sm_done && vs_fall) begin
          // Results arrived exactly on the frame boundary: show them now and start the next frame.
          commit_direct = 1'b1;
          state_nxt     = TICK;
        end else if (sm_done) begin
          stage_load = 1'b1;
          state_nxt  = IDLE;
        end else begin
          set_overrun = vs_fall;
          if (timer == TMR_LAST) begin
            set_timeout = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: staging and pending are cleared too, so a frame staged before reset can never reach the PPU.
      vsync_q       <= 1'b0;
      sm_tick       <= 1'b0;
      busy          <= 1'b0;
      frame_count   <= '0;
      timer         <= '0;
      stage_sprites <= '0;
      stage_statics <= '0;
      pending       <= 1'b0;
      ppu_sprites   <= '0;
      ppu_statics   <= '0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      vsync_q <= vsync;
      sm_tick <= (state_nxt == TICK);
      busy    <= (state_nxt == WAIT);

      if (vs_fall && enable) frame_count <= frame_count + FCNT_W'(1);

      if (state == TICK)      timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);

      if (stage_load) begin
        stage_sprites <= sm_sprites;
        stage_statics <= sm_statics;
        pending       <= 1'b1;
      end
      if (commit_stage) begin
        ppu_sprites <= stage_sprites;
        ppu_statics <= stage_statics;
        pending     <= 1'b0;
      end
      if (commit_direct) begin
        ppu_sprites <= sm_sprites;
        ppu_statics <= sm_statics;
        pending     <= 1'b0;
      end

      // A set event in the same cycle as clear_flags wins.
      overrun <= set_overrun | (overrun & ~clear_flags);
      timeout <= set_timeout | (timeout & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: directed frame scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the frame rules.
module tb_frame_sync_ctrl;

  localparam int SPRITE_W = 64;
  localparam int STATIC_W = 1;
  localparam int TIMEOUT  = 50;
  localparam int FCNT_W   = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                vsync;
  logic                enable;
  logic                clear_flags;
  logic                sm_tick;
  logic                sm_done;
  logic [SPRITE_W-1:0] sm_sprites;
  logic [STATIC_W-1:0] sm_statics;
  logic [SPRITE_W-1:0] ppu_sprites;
  logic [STATIC_W-1:0] ppu_statics;
  logic [FCNT_W-1:0]   frame_count;
  logic                busy;
  logic                overrun;
  logic                timeout;

  frame_sync_ctrl #(
    .SPRITE_W(SPRITE_W), .STATIC_W(STATIC_W), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)
  ) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .enable(enable),
    .clear_flags(clear_flags), .sm_tick(sm_tick), .sm_done(sm_done),
    .sm_sprites(sm_sprites), .sm_statics(sm_statics),
    .ppu_sprites(ppu_sprites), .ppu_statics(ppu_statics),
    .frame_count(frame_count), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int busy_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "ticking", "waiting" (with elapsed cycle count) or idle;
  // finished results sit in a one-deep queue until the next frame boundary.
  bit                  m_prev_vs;
  bit                  m_ticking;
  bit                  m_waiting;
  int                  m_wait_len;
  logic [64:0]         m_stage[$];
  logic [SPRITE_W-1:0] e_spr;
  logic [STATIC_W-1:0] e_sta;
  int                  e_fcnt;
  bit                  e_ov, e_to;

  function automatic void model_reset();
    m_prev_vs  = 1'b0;
    m_ticking  = 1'b0;
    m_waiting  = 1'b0;
    m_wait_len = 0;
    m_stage.delete();
    e_spr  = '0;
    e_sta  = '0;
    e_fcnt = 0;
    e_ov   = 1'b0;
    e_to   = 1'b0;
  endfunction

  function automatic void model_step();
    bit fall     = m_prev_vs && !vsync;
    bit tick_now = 1'b0;
    bit set_ov   = 1'b0;
    bit set_to   = 1'b0;
    m_prev_vs = vsync;
    if (fall && enable) e_fcnt = (e_fcnt + 1) % (1 << FCNT_W);
    if (m_ticking) begin
      m_waiting  = 1'b1;
      m_wait_len = 0;
    end else if (m_waiting) begin
      if (sm_done && fall) begin
        e_spr = sm_sprites;
        e_sta = sm_statics;
        m_stage.delete();
        m_waiting = 1'b0;
        tick_now  = 1'b1;
      end else if (sm_done) begin
        m_stage.delete();
        m_stage.push_back({sm_statics, sm_sprites});
        m_waiting = 1'b0;
      end else begin
        set_ov = fall;
        m_wait_len++;
        if (m_wait_len == TIMEOUT) begin
          set_to    = 1'b1;
          m_waiting = 1'b0;
        end
      end
    end else if (fall && enable) begin
      if (m_stage.size() > 0) {e_sta, e_spr} = m_stage.pop_front();
      tick_now = 1'b1;
    end
    m_ticking = tick_now;
    e_ov = set_ov | (e_ov & !clear_flags);
    e_to = set_to | (e_to & !clear_flags);
  endfunction

  task automatic check_all();
    check("sm_tick", sm_tick, m_ticking);
    check("busy", busy, m_waiting);
    check("ppu_sprites", ppu_sprites, e_spr);
    check("ppu_statics", ppu_statics, e_sta);
    check("frame_count", frame_count, e_fcnt);
    check("overrun", overrun, e_ov);
    check("timeout", timeout, e_to);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_all();
    tick_cnt += int'(sm_tick);
    busy_cnt += int'(busy);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic vfall();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic done_pulse(input logic [63:0] spr, input logic st);
    sm_sprites = spr;
    sm_statics = st;
    sm_done    = 1'b1;
    step();
    sm_done    = 1'b0;
    sm_sprites = {$urandom, $urandom};
    sm_statics = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, sm_tick, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_spr"}, ppu_sprites, 0);
    check({tag, "_sta"}, ppu_statics, 0);
    check({tag, "_fcnt"}, frame_count, 0);
    check({tag, "_ov"}, overrun, 0);
    check({tag, "_to"}, timeout, 0);
  endtask

  // Reset is raised between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1 check_zero(tag);
    model_reset();
    @(posedge clock);
    #1 check_all();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; enable = 1'b1; clear_flags = 1'b0;
    sm_done = 1'b0; sm_sprites = '0; sm_statics = '0;
    model_reset();
    #2 check_zero("rst");
    #6 reset = 1'b0;

    // Idle with vsync held high.
    cycles(9);
    check("idle_fcnt", frame_count, 0);
    check("idle_tick_cnt", tick_cnt, 0);

    // Basic frame: tick one cycle after the edge, 20 busy cycles, commit at next edge.
    vsync = 1'b0;
    step();
    check("tick_latency", sm_tick, 1);
    vsync = 1'b1;
    busy_cnt = 0;
    cycles(20);
    done_pulse(64'hA5, 1'b1);
    check("busy_len", busy_cnt, 20);
    check("ppu_before_edge", ppu_sprites, 0);
    cycles(5);
    check("ppu_still_0", ppu_sprites, 0);
    vsync = 1'b0;
    step();
    check("ppu_after_edge", ppu_sprites, 64'hA5);
    check("fcnt_2", frame_count, 2);
    check("tick2", sm_tick, 1);
    vsync = 1'b1;

    // Overrun: two edges while waiting, then late results.
    tick_cnt = 0;
    cycles(5);
    vfall();
    cycles(5);
    vfall();
    cycles(2);
    done_pulse(64'h3C, 1'b0);
    check("ov_set", overrun, 1);
    check("ov_no_tick", tick_cnt, 0);
    check("ov_ppu_held", ppu_sprites, 64'hA5);
    check("ov_fcnt", frame_count, 4);
    cycles(3);
    vsync = 1'b0;
    step();
    check("ov_ppu_commit", ppu_sprites, 64'h3C);
    check("ov_sticky", overrun, 1);
    vsync = 1'b1;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("ov_cleared", overrun, 0);

    // Done coincident with the frame edge commits directly.
    cycles(4);
    vsync = 1'b0; sm_done = 1'b1; sm_sprites = 64'h77; sm_statics = 1'b1;
    step();
    check("sim_ppu", ppu_sprites, 64'h77);
    check("sim_sta", ppu_statics, 1);
    check("sim_tick", sm_tick, 1);
    check("sim_no_ov", overrun, 0);
    vsync = 1'b1; sm_done = 1'b0;

    // Timeout: nobody answers.
    busy_cnt = 0;
    cycles(60);
    check("to_set", timeout, 1);
    check("to_busy_len", busy_cnt, 50);
    check("to_busy_low", busy, 0);
    check("to_ppu_kept", ppu_sprites, 64'h77);
    done_pulse(64'hDEAD, 1'b0);
    vsync = 1'b0;
    step();
    check("late_done_ignored", ppu_sprites, 64'h77);
    vsync = 1'b1;

    // Staged data held across a disabled edge, then dropped by reset.
    step();
    cycles(3);
    done_pulse(64'hBEEF, 1'b0);
    enable = 1'b0;
    vfall();
    check("dis_ppu_held", ppu_sprites, 64'h77);
    check("dis_no_tick", busy, 0);
    enable = 1'b1;
    async_reset("rst_idle");
    cycles(2);
    vsync = 1'b0;
    step();
    check("fresh_tick", sm_tick, 1);
    check("no_stale_data", ppu_sprites, 0);
    vsync = 1'b1;
    cycles(4);
    async_reset("rst_wait");
    cycles(2);
    vfall();
    cycles(3);
    done_pulse(64'h1234, 1'b1);
    vsync = 1'b0;
    step();
    check("post_rst_commit", ppu_sprites, 64'h1234);
    vsync = 1'b1;

    // Randomized run against the model; alternates chatty and sluggish statemachine phases.
    for (int i = 0; i < 4000; i++) begin
      int rate = ((i / 300) % 2 == 1) ? 90 : 12;
      vsync       = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      enable      = ($urandom_range(0, 9) != 0);
      sm_done     = ($urandom_range(0, rate - 1) == 0);
      clear_flags = ($urandom_range(0, 39) == 0);
      sm_sprites  = {$urandom, $urandom};
      sm_statics  = 1'($urandom);
      if ($urandom_range(0, 999) == 0) async_reset("rst_rand");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
